// File: rtl/power_pkg.sv
// Shared types and default parameters for the power transition scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package power_pkg;

    localparam int DEF_NUM_DOMAINS    = 8;
    localparam int DEF_SETTLE_CYCLES  = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SETTLE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/power_rr_picker.sv
// Round-robin picker: first set request bit at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; valid simply reflects whether any request bit is set.
// Ports: req (request vector), ptr (search start) -> valid, index.
module power_rr_picker #(
    parameter int N = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] index
);

    int            pos;
    logic [IW-1:0] sel;

    // Walk offsets from farthest to nearest so the nearest hit is written last
    // and wins; avoids a loop break.
    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = 0;
        sel   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            pos = (int'(ptr) + off) % N;
            sel = IW'(pos);
            if (req[sel]) begin
                valid = 1'b1;
                index = sel;
            end
        end
    end

endmodule

// File: rtl/power_transition_scheduler.sv
// Serialises power-domain wake/sleep transitions, one grant at a time, with a settle gap.
// Latency: request in IDLE -> registered grant next cycle; SETTLE_CYCLES gap after each grant.
// Backpressure: requests are level and wait while busy; a grant ends on done or timeout.
// Ports: wake_req/sleep_req/done per domain in; grant (one-hot), grant_is_wake, active_id,
//        busy, timeout_err (pulse), timeout_id (held) out.
module power_transition_scheduler
    import power_pkg::*;
#(
    parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDW = $clog2(NUM_DOMAINS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_DOMAINS-1:0] wake_req,
    input  logic [NUM_DOMAINS-1:0] sleep_req,
    input  logic [NUM_DOMAINS-1:0] done,
    output logic [NUM_DOMAINS-1:0] grant,
    output logic                   grant_is_wake,
    output logic [IDW-1:0]         active_id,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [IDW-1:0]         timeout_id
);

    // Counters are one value wider than strictly needed so a zero parameter
    // still yields a legal width.
    localparam int TMW = $clog2(TIMEOUT_CYCLES + 2);
    localparam int SCW = $clog2(SETTLE_CYCLES + 2);

    sched_state_t     state;
    logic [IDW-1:0]   rr_ptr;
    logic [TMW-1:0]   timer;
    logic [SCW-1:0]   settle_cnt;

    logic [NUM_DOMAINS-1:0] sleep_only;
    logic                   wake_vld;
    logic                   sleep_vld;
    logic [IDW-1:0]         wake_idx;
    logic [IDW-1:0]         sleep_idx;
    logic [IDW-1:0]         next_ptr;
    logic                   granted_done;
    logic                   timer_expired;
    logic                   settle_last;

    // A domain raising both requests is a wake only.
    assign sleep_only = sleep_req & ~wake_req;

    power_rr_picker #(.N(NUM_DOMAINS)) u_wake_pick (
        .req   (wake_req),
        .ptr   (rr_ptr),
        .valid (wake_vld),
        .index (wake_idx)
    );

    power_rr_picker #(.N(NUM_DOMAINS)) u_sleep_pick (
        .req   (sleep_only),
        .ptr   (rr_ptr),
        .valid (sleep_vld),
        .index (sleep_idx)
    );

    // Only the granted domain's done bit is ever looked at.
    assign granted_done  = done[active_id];
    assign timer_expired = (int'(timer) >= TIMEOUT_CYCLES);
    assign settle_last   = ((int'(settle_cnt) + 1) >= SETTLE_CYCLES);
    assign next_ptr      = (active_id == IDW'(NUM_DOMAINS - 1)) ? '0 : active_id + 1'b1;
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            grant         <= '0;
            grant_is_wake <= 1'b0;
            active_id     <= '0;
            timeout_err   <= 1'b0;
            timeout_id    <= '0;
            rr_ptr        <= '0;
            timer         <= '0;
            settle_cnt    <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wake_vld) begin
                        grant         <= NUM_DOMAINS'(1) << wake_idx;
                        grant_is_wake <= 1'b1;
                        active_id     <= wake_idx;
                        timer         <= '0;
                        state         <= ST_GRANT;
                    end else if (sleep_vld) begin
                        grant         <= NUM_DOMAINS'(1) << sleep_idx;
                        grant_is_wake <= 1'b0;
                        active_id     <= sleep_idx;
                        timer         <= '0;
                        state         <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // done takes precedence over a timeout landing on the same edge.
                    if (granted_done || timer_expired) begin
                        grant      <= '0;
                        rr_ptr     <= next_ptr;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                        if (!granted_done) begin
                            timeout_err <= 1'b1;
                            timeout_id  <= active_id;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_last) begin
                        state <= ST_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_power_transition_scheduler.sv
// Self-checking bench for power_transition_scheduler with a grant scoreboard.
// Latency: n/a (simulation only).
// Backpressure: n/a.
module tb_power_transition_scheduler;

    localparam int N      = 8;
    localparam int SETTLE = 16;
    localparam int TMO    = 255;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] wake_req;
    logic [N-1:0] sleep_req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic         grant_is_wake;
    logic [2:0]   active_id;
    logic         busy;
    logic         timeout_err;
    logic [2:0]   timeout_id;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [N-1:0] grant;
        logic         wake;
        logic [2:0]   id;
    } exp_t;

    exp_t exp_q[$];

    power_transition_scheduler #(
        .NUM_DOMAINS   (N),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wake_req     (wake_req),
        .sleep_req    (sleep_req),
        .done         (done),
        .grant        (grant),
        .grant_is_wake(grant_is_wake),
        .active_id    (active_id),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .timeout_id   (timeout_id)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int limit, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        while (!ok && cycles < limit) begin
            tick();
            cycles++;
            if (grant != '0) ok = 1'b1;
        end
    endtask

    // Completes the current transition, drops all requests, returns at the first IDLE sample.
    task automatic finish_xfer(input logic [N-1:0] mask, output bit ok);
        done = mask;
        wake_req = '0;
        sleep_req = '0;
        tick();
        done = '0;
        ok = 1'b0;
        for (int i = 0; i < SETTLE + 5 && !ok; i++) begin
            if (!busy) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wake_req = '0;
        sleep_req = '0;
        done = '0;
        tick();
        tick();
        n_cmp++; if (grant !== '0) begin n_bad++; $display("FAIL reset_grant: got %h want 00", grant); end
        n_cmp++; if ({busy, timeout_err, grant_is_wake} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {busy, timeout_err, grant_is_wake}); end
        n_cmp++; if ({active_id, timeout_id} !== 6'd0) begin n_bad++; $display("FAIL reset_ids: got %0d/%0d want 0/0", active_id, timeout_id); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_wake;
        exp_t e;
        int gap, busy_cnt;
        bit ok;
        wake_req = 8'h24;
        exp_q.push_back('{grant: 8'h04, wake: 1'b1, id: 3'd2});
        exp_q.push_back('{grant: 8'h20, wake: 1'b1, id: 3'd5});
        tick();
        e = exp_q.pop_front();
        n_cmp++; if ({grant, grant_is_wake, active_id} !== e) begin n_bad++; $display("FAIL basic_first: got %h/%b/%0d want %h/%b/%0d", grant, grant_is_wake, active_id, e.grant, e.wake, e.id); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        wake_req = 8'h20;          // dropping the granted request must not revoke the grant
        repeat (3) tick();
        n_cmp++; if ({grant, grant_is_wake} !== {8'h04, 1'b1}) begin n_bad++; $display("FAIL basic_hold: got %h/%b want 04/1", grant, grant_is_wake); end
        done = 8'h04;
        tick();
        done = '0;
        gap = 0;
        busy_cnt = 0;
        while (grant == '0 && gap < 60) begin
            gap++;
            if (busy) busy_cnt++;
            tick();
        end
        n_cmp++; if (gap != SETTLE + 1) begin n_bad++; $display("FAIL basic_gap: got %0d want %0d", gap, SETTLE + 1); end
        n_cmp++; if (busy_cnt != SETTLE) begin n_bad++; $display("FAIL basic_settle_busy: got %0d want %0d", busy_cnt, SETTLE); end
        e = exp_q.pop_front();
        n_cmp++; if ({grant, grant_is_wake, active_id} !== e) begin n_bad++; $display("FAIL basic_second: got %h/%b/%0d want %h/%b/%0d", grant, grant_is_wake, active_id, e.grant, e.wake, e.id); end
        finish_xfer(8'h20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_idle: got busy want idle"); end
    endtask

    task automatic test_wake_priority;
        exp_t e;
        int cyc;
        bit ok;
        sleep_req = 8'h01;
        wake_req = 8'h80;
        exp_q.push_back('{grant: 8'h80, wake: 1'b1, id: 3'd7});
        exp_q.push_back('{grant: 8'h01, wake: 1'b0, id: 3'd0});
        wait_grant(5, cyc, ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || {grant, grant_is_wake, active_id} !== e) begin n_bad++; $display("FAIL prio_wake: got %h/%b/%0d want %h/%b/%0d", grant, grant_is_wake, active_id, e.grant, e.wake, e.id); end
        done = 8'h80;
        wake_req = '0;
        tick();
        done = '0;
        wait_grant(40, cyc, ok);
        n_cmp++; if (!ok || cyc != SETTLE + 1) begin n_bad++; $display("FAIL prio_gap: got %0d want %0d", cyc, SETTLE + 1); end
        e = exp_q.pop_front();
        n_cmp++; if ({grant, grant_is_wake, active_id} !== e) begin n_bad++; $display("FAIL prio_sleep: got %h/%b/%0d want %h/%b/%0d", grant, grant_is_wake, active_id, e.grant, e.wake, e.id); end
        finish_xfer(8'h01, ok);
        wake_req = 8'h10;
        sleep_req = 8'h10;
        exp_q.push_back('{grant: 8'h10, wake: 1'b1, id: 3'd4});
        wait_grant(5, cyc, ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || {grant, grant_is_wake, active_id} !== e) begin n_bad++; $display("FAIL prio_both: got %h/%b/%0d want %h/%b/%0d", grant, grant_is_wake, active_id, e.grant, e.wake, e.id); end
        finish_xfer(8'h10, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL prio_idle: got busy want idle"); end
    endtask

    task automatic test_timeout;
        exp_t e;
        int cyc, gcyc, pulses, busy_lo;
        bit ok;
        wake_req = 8'h08;
        exp_q.push_back('{grant: 8'h08, wake: 1'b1, id: 3'd3});
        wait_grant(5, cyc, ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || {grant, grant_is_wake, active_id} !== e) begin n_bad++; $display("FAIL tmo_grant: got %h/%b/%0d want %h/%b/%0d", grant, grant_is_wake, active_id, e.grant, e.wake, e.id); end
        gcyc = 0;
        while (grant == 8'h08 && gcyc < 400) begin
            gcyc++;
            tick();
        end
        wake_req = '0;
        n_cmp++; if (gcyc != TMO + 1) begin n_bad++; $display("FAIL tmo_length: got %0d want %0d", gcyc, TMO + 1); end
        n_cmp++; if ({grant, timeout_err, busy} !== {8'h00, 1'b1, 1'b1}) begin n_bad++; $display("FAIL tmo_event: got %h/%b/%b want 00/1/1", grant, timeout_err, busy); end
        n_cmp++; if (timeout_id !== 3'd3) begin n_bad++; $display("FAIL tmo_id: got %0d want 3", timeout_id); end
        pulses = 0;
        busy_lo = 0;
        for (int i = 0; i < SETTLE; i++) begin
            if (timeout_err) pulses++;
            if (!busy) busy_lo++;
            tick();
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL tmo_pulses: got %0d want 1", pulses); end
        n_cmp++; if (busy_lo != 0) begin n_bad++; $display("FAIL tmo_settle_busy: got %0d idle samples want 0", busy_lo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: got %b want 0", busy); end
    endtask

    task automatic test_done_race;
        exp_t e;
        int cyc, pulses;
        bit ok;
        wake_req = 8'h08;
        exp_q.push_back('{grant: 8'h08, wake: 1'b1, id: 3'd3});
        wait_grant(5, cyc, ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || {grant, grant_is_wake, active_id} !== e) begin n_bad++; $display("FAIL race_grant: got %h/%b/%0d want %h/%b/%0d", grant, grant_is_wake, active_id, e.grant, e.wake, e.id); end
        done = 8'h20;              // foreign done must be ignored
        tick();
        done = '0;
        n_cmp++; if (grant !== 8'h08) begin n_bad++; $display("FAIL race_foreign_done: got %h want 08", grant); end
        repeat (TMO - 1) tick();   // timer now at its limit
        n_cmp++; if (grant !== 8'h08) begin n_bad++; $display("FAIL race_pre: got %h want 08", grant); end
        done = 8'h08;
        wake_req = '0;
        tick();
        done = '0;
        n_cmp++; if ({grant, timeout_err, busy} !== {8'h00, 1'b0, 1'b1}) begin n_bad++; $display("FAIL race_done_wins: got %h/%b/%b want 00/0/1", grant, timeout_err, busy); end
        pulses = 0;
        for (int i = 0; i < SETTLE; i++) begin
            if (timeout_err) pulses++;
            tick();
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL race_pulses: got %0d want 0", pulses); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL race_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_grant;
        exp_t e;
        int cyc;
        bit ok;
        wake_req = 8'h40;
        exp_q.push_back('{grant: 8'h40, wake: 1'b1, id: 3'd6});
        wait_grant(5, cyc, ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || {grant, grant_is_wake, active_id} !== e) begin n_bad++; $display("FAIL rst_grant: got %h/%b/%0d want %h/%b/%0d", grant, grant_is_wake, active_id, e.grant, e.wake, e.id); end
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (grant !== '0) begin n_bad++; $display("FAIL rst_async_grant: got %h want 00", grant); end
        n_cmp++; if ({busy, timeout_err, grant_is_wake, active_id, timeout_id} !== 9'd0) begin n_bad++; $display("FAIL rst_async_outs: got %b/%b/%b/%0d/%0d want all 0", busy, timeout_err, grant_is_wake, active_id, timeout_id); end
        wake_req = '0;
        tick();
        rst_n = 1'b1;
        tick();
        wake_req = 8'h82;          // pointer back at 0 must pick domain 1 over 7
        exp_q.push_back('{grant: 8'h02, wake: 1'b1, id: 3'd1});
        wait_grant(5, cyc, ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || cyc != 1 || {grant, grant_is_wake, active_id} !== e) begin n_bad++; $display("FAIL rst_regrant: got %h/%b/%0d after %0d want %h/%b/%0d after 1", grant, grant_is_wake, active_id, cyc, e.grant, e.wake, e.id); end
        finish_xfer(8'h02, ok);
        n_cmp++; if (!ok || timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_final_idle: got ok=%b err=%b want 1/0", ok, timeout_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_wake();
        test_wake_priority();
        test_timeout();
        test_done_race();
        test_reset_mid_grant();
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
